// File: rtl/parity_pkg.sv
// ============================================================================
// Module      : parity_pkg
// Description : Shared types and constants for the parity stream checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic EVEN      = 1'b0;
    localparam logic ODD       = 1'b1;
    localparam int   ERR_CNT_W = 16;

    // Beat counter only needs to reach MAX_BEATS-1; keep at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/parity_stream_checker_if.sv
// ============================================================================
// Module      : parity_stream_checker_if
// Description : Beat input and frame result handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parity_stream_checker_if #(
    parameter int DATA_W = 8
);
    logic              odd_mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_par;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              out_par;
    logic              out_err;
    logic              out_ovf;

    modport master (
        output odd_mode, in_valid, in_data, in_last, in_par, out_ready,
        input  in_ready, out_valid, out_par, out_err, out_ovf
    );

    modport slave (
        input  odd_mode, in_valid, in_data, in_last, in_par, out_ready,
        output in_ready, out_valid, out_par, out_err, out_ovf
    );
endinterface

`default_nettype wire

// File: rtl/parity_tree.sv
// ============================================================================
// Module      : parity_tree
// Description : Combinational XOR reduction of a DATA_W-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_tree #(
    parameter int DATA_W = 8
) (
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_par
);
    logic [DATA_W-1:0] chain;

    assign chain[0] = i_data[0];

    generate
        for (genvar i = 1; i < DATA_W; i++) begin : g_chain
            assign chain[i] = chain[i-1] ^ i_data[i];
        end
    endgenerate

    assign o_par = chain[DATA_W-1];
endmodule

`default_nettype wire

// File: rtl/parity_stream_checker.sv
// ============================================================================
// Module      : parity_stream_checker
// Description : Accumulates frame parity over beats and checks the received
//               parity bit. Define PARITY_ERR_CNT_EN to add the err_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    parity_stream_checker_if.slave bus
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);
    localparam int CNT_W = cnt_width(MAX_BEATS);

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               par_q, par_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    logic               beat_red;
    logic               mode_eff;
    logic               last_slot;
    logic               frame_par;

    parity_tree #(.DATA_W(DATA_W)) u_tree (
        .i_data (bus.in_data),
        .o_par  (beat_red)
    );

    // The first beat of a frame takes the live mode; later beats reuse the latched one.
    assign mode_eff  = (cnt_q == '0) ? bus.odd_mode : mode_q;
    assign last_slot = (cnt_q == CNT_W'(MAX_BEATS - 1));
    assign frame_par = acc_q ^ beat_red ^ mode_eff;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        par_d   = par_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC: begin
                if (bus.in_valid) begin
                    if (bus.in_last || last_slot) begin
                        par_d   = frame_par;
                        ovf_d   = ~bus.in_last;
                        err_d   = (bus.in_par != frame_par) | ~bus.in_last;
                        mode_d  = mode_eff;
                        state_d = HOLD;
                    end else begin
                        acc_d  = acc_q ^ beat_red;
                        cnt_d  = cnt_q + CNT_W'(1);
                        mode_d = mode_eff;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACC;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= EVEN;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            par_q   <= par_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_par   = par_q;
    assign bus.out_err   = err_q;
    assign bus.out_ovf   = ovf_q;

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == HOLD) && bus.out_ready && err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
// ============================================================================
// Module      : tb_parity_stream_checker
// Description : Directed self-checking bench (DATA_W=8, MAX_BEATS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_stream_checker;
    import parity_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    parity_stream_checker_if #(.DATA_W(8)) bus ();

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;
`endif

    parity_stream_checker #(
        .DATA_W    (8),
        .MAX_BEATS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] data, input logic last, input logic par, input logic mode);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        bus.in_par   = par;
        bus.odd_mode = mode;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Checks a presented result, then completes the handshake.
    task automatic result(input string tag, input logic par, input logic err, input logic ovf);
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'h1);
        chk({tag, "_par"},   16'(bus.out_par),   16'(par));
        chk({tag, "_err"},   16'(bus.out_err),   16'(err));
        chk({tag, "_ovf"},   16'(bus.out_ovf),   16'(ovf));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_done_valid"}, 16'(bus.out_valid), 16'h0);
        chk({tag, "_done_ready"}, 16'(bus.in_ready),  16'h1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.odd_mode  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_par    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  16'(bus.in_ready),  16'h1);
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_out_par",   16'(bus.out_par),   16'h0);
        chk("rst_out_err",   16'(bus.out_err),   16'h0);
        chk("rst_out_ovf",   16'(bus.out_ovf),   16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Even good frame: ^03=0, ^01=1 -> par 1
        beat(8'h03, 1'b0, 1'b0, EVEN);
        chk("even_mid_valid", 16'(bus.out_valid), 16'h0);
        beat(8'h01, 1'b1, 1'b1, EVEN);
        result("even", 1'b1, 1'b0, 1'b0);

        // Odd single beat: ^07=1, ^odd -> par 0, in_par 1 -> error
        beat(8'h07, 1'b1, 1'b1, ODD);
        result("odd", 1'b0, 1'b1, 1'b0);

        // Mode latched on first beat (odd), change ignored -> par 1
        beat(8'h00, 1'b0, 1'b0, ODD);
        beat(8'h00, 1'b1, 1'b1, EVEN);
        result("latch", 1'b1, 1'b0, 1'b0);

        // Overflow: four beats of 01 without last -> par 0, ovf, err
        beat(8'h01, 1'b0, 1'b0, EVEN);
        beat(8'h01, 1'b0, 1'b0, EVEN);
        beat(8'h01, 1'b0, 1'b0, EVEN);
        beat(8'h01, 1'b0, 1'b0, EVEN);
        chk("ovf_in_ready", 16'(bus.in_ready), 16'h0);
        result("ovf", 1'b0, 1'b1, 1'b1);
        beat(8'hFF, 1'b1, 1'b0, EVEN);
        result("ovf_tail", 1'b0, 1'b0, 1'b0);

        // Backpressure with a beat offered during HOLD
        beat(8'h80, 1'b1, 1'b1, EVEN);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 16'(bus.out_valid), 16'h1);
            chk("bp_ready", 16'(bus.in_ready),  16'h0);
            chk("bp_par",   16'(bus.out_par),   16'h1);
            chk("bp_err",   16'(bus.out_err),   16'h0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        result("bp", 1'b1, 1'b0, 1'b0);
        beat(8'h00, 1'b1, 1'b0, EVEN);
        result("bp_after", 1'b0, 1'b0, 1'b0);

        // Reset mid-frame after 2 of 3 beats (accumulator would be 1)
        beat(8'h01, 1'b0, 1'b0, EVEN);
        beat(8'h00, 1'b0, 1'b0, EVEN);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 16'(bus.out_valid), 16'h0);
        chk("mid_rst_ready", 16'(bus.in_ready),  16'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(8'h00, 1'b1, 1'b0, EVEN);
        result("post_rst", 1'b0, 1'b0, 1'b0);

        // Reset while holding a result discards it
        beat(8'h01, 1'b1, 1'b1, EVEN);
        chk("hold_pre_valid", 16'(bus.out_valid), 16'h1);
        rst_n = 1'b0;
        #2;
        chk("hold_rst_valid", 16'(bus.out_valid), 16'h0);
        chk("hold_rst_par",   16'(bus.out_par),   16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three error frames and two good frames
        for (int i = 0; i < 3; i++) begin
            beat(8'h07, 1'b1, 1'b1, ODD);
            result("cnt_bad", 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            beat(8'h03, 1'b1, 1'b0, EVEN);
            result("cnt_good", 1'b0, 1'b0, 1'b0);
        end
`ifdef PARITY_ERR_CNT_EN
        chk("err_cnt", err_cnt, 16'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/parity_stream_checker.md
PARITY_STREAM_CHECKER -- requirements
Module: parity_stream_checker

Interface
REQ-001 Parameter DATA_W, default 8, is the beat data width and SHALL be at least 1.
REQ-002 Parameter MAX_BEATS, default 16, is the maximum beats per frame and SHALL be at least 1.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 odd_mode  input  1  selects the mode: 0 means even parity, 1 means odd parity.
REQ-006 in_valid  input  1  indicates that a beat is present.
REQ-007 in_data  input  DATA_W  is the beat payload.
REQ-008 in_last  input  1  marks the final beat of a frame.
REQ-009 in_par  input  1  is the received parity bit and SHALL be sampled only on the last beat.
REQ-010 in_ready  output  1  indicates that the block can accept a beat.
REQ-011 out_valid  output  1  indicates that a frame result is presented.
REQ-012 out_ready  input  1  indicates that the consumer accepts the result.
REQ-013 out_par  output  1  is the computed frame parity bit.
REQ-014 out_err  output  1  SHALL be 1 when in_par differs from out_par, or when the frame overflowed.
REQ-015 out_ovf  output  1  SHALL be 1 when the frame was truncated at MAX_BEATS.

Function
REQ-016 The FSM SHALL have two states: ACC, which accepts beats, and HOLD, which presents a result.
REQ-017 in_ready SHALL be 1 in ACC and 0 in HOLD; out_valid SHALL be 1 in HOLD and 0 in ACC.
REQ-018 A beat SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-019 Each accepted non-final beat SHALL XOR the XOR-reduction of in_data into the accumulator and increment the beat count.
REQ-020 odd_mode SHALL be latched on the first beat of a frame; later changes SHALL NOT affect that frame.
REQ-021 On the final beat, out_par SHALL equal accumulator XOR the reduction of in_data XOR the latched odd_mode.
- "Final beat" means an accepted beat with in_last=1, or the MAX_BEATS-th beat.
REQ-022 The final beat SHALL also latch out_err and out_ovf and move the FSM to HOLD.
- out_valid SHALL assert on the next cycle (latency 1).
REQ-023 If the MAX_BEATS-th beat has in_last=0, the block SHALL set out_ovf=1 and out_err=1.
- The remaining beats of that frame SHALL be treated as a new frame.
REQ-024 In HOLD, out_par, out_err and out_ovf SHALL hold stable until out_valid and out_ready are both 1.
REQ-025 On that handshake, the block SHALL return to ACC and clear the accumulator and beat count.
- in_ready SHALL be 1 on the following cycle; there is no same-cycle bypass.
REQ-026 A single-beat frame (in_last=1 on the first beat) SHALL be legal and produce a result after 1 cycle.
REQ-027 When in_valid is 0 in ACC, all state SHALL be held.

Reset
REQ-028 While rst_n is 0, the block SHALL force the FSM to ACC and clear the accumulator, beat count, out_par, out_err and out_ovf.
- out_valid SHALL then read 0 and in_ready SHALL read 1.
REQ-029 Assertion of rst_n mid-frame or in HOLD SHALL discard the partial frame or pending result without emitting it.

Configuration
REQ-030 When PARITY_ERR_CNT_EN is defined, the block SHALL add the output port err_cnt (16 bits).
- err_cnt increments once per result handshake with out_err=1.
- err_cnt saturates at 16'hFFFF.
- err_cnt resets to 0.
REQ-031 When PARITY_ERR_CNT_EN is not defined, the err_cnt port and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-032 The shared package parity_pkg SHALL hold:
- the FSM state typedef (ACC, HOLD);
- the parity-mode constants EVEN=0 and ODD=1;
- the error-counter width constant of 16.
REQ-033 The XOR reduction SHALL be a sub-module parity_tree, parametrised by DATA_W, with a combinational DATA_W-to-1 output.

Verification
REQ-034 Even-parity good frame: DATA_W=8, odd_mode=0, beats 8'h03, 8'h01 with in_last, and in_par=1 -> out_par=1, out_err=0, out_valid one cycle after the last beat.
REQ-035 Odd-mode error frame: odd_mode=1, single beat 8'h07 with in_last, and in_par=1 -> out_par=0, out_err=1.
REQ-036 Overflow: MAX_BEATS=4, five beats with in_last only on the fifth -> first result has out_ovf=1 and out_err=1; the fifth beat forms its own frame.
REQ-037 Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, and no beat is accepted; the result handshake occurs on the cycle out_ready rises.
REQ-038 Reset mid-frame: rst_n pulsed low after 2 of 3 beats -> no out_valid, in_ready=1, and the next frame computes from a cleared accumulator.
REQ-039 With PARITY_ERR_CNT_EN defined: 3 erroneous frames and 2 good frames -> err_cnt=3.
